// File: rtl/store_buffer.sv
// M-stage store buffer for sw/sh/sb. It checks alignment, builds byte enables and
// lane-replicated data, queues stores in a FIFO, drains them to memory and flags load hazards.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic        sw,
   input  logic        sh,
   input  logic        sb,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [31:0] st_pc,
   output logic        st_ready,
   output logic        exc_ades,
   output logic [31:0] m_data_addr,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   output logic [31:0] m_inst_addr,
   input  logic        mem_ready,
   input  logic [31:0] ld_addr,
   output logic        ld_conflict,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {ST_NONE, ST_WORD, ST_HALF, ST_BYTE} st_kind_e;

   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0] valid_q;
   logic             exc_ades_q;
   logic [31:0]      addr_q   [DEPTH];
   logic [31:0]      wdata_q  [DEPTH];
   logic [3:0]       byteen_q [DEPTH];
   logic [31:0]      pc_q     [DEPTH];

   st_kind_e    kind;
   logic        misaligned;
   logic [3:0]  byteen_n;
   logic [31:0] wdata_n;
   logic        full, accept, do_enq, do_deq, hit;
   logic [AW-1:0] wr_idx, rd_idx;

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   // NOTE: each variable gets a default first, so that no path through the block leaves it unassigned and infers a latch.
   always_comb begin
      kind       = ST_NONE;
      misaligned = 1'b0;
      byteen_n   = 4'b0000;
      wdata_n    = st_data;
      if (sw)      kind = ST_WORD;
      else if (sh) kind = ST_HALF;
      else if (sb) kind = ST_BYTE;
      case (kind)
         ST_WORD: begin
            misaligned = (st_addr[1:0] != 2'b00);
            byteen_n   = 4'b1111;
         end
         ST_HALF: begin
            misaligned = st_addr[0];
            byteen_n   = st_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n    = {2{st_data[15:0]}};
         end
         ST_BYTE: begin
            byteen_n   = 4'b0001 << st_addr[1:0];
            wdata_n    = {4{st_data[7:0]}};
         end
         default: ;
      endcase
   end

   assign accept = st_valid && st_ready && (kind != ST_NONE);
   assign do_enq = accept && !misaligned;
   assign do_deq = !empty && mem_ready;

   // NOTE: sequential state is updated with non-blocking assignments so that every register samples values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         valid_q    <= '0;
         exc_ades_q <= 1'b0;
      end else begin
         exc_ades_q <= accept && misaligned;
         if (do_enq) begin
            valid_q[wr_idx] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_deq) begin
            valid_q[rd_idx] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PW'(1);
         end
      end
   end

   // NOTE: entry storage has no reset. The valid bits and pointers alone decide whether an entry is live.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         addr_q[wr_idx]   <= st_addr;
         wdata_q[wr_idx]  <= wdata_n;
         byteen_q[wr_idx] <= byteen_n;
         pc_q[wr_idx]     <= st_pc;
      end
   end

   // A load hazard is checked against every live entry, including the head.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) hit = 1'b1;
   end

   logic unused_ld_bits;
   assign unused_ld_bits = ^ld_addr[1:0];

   assign ld_conflict   = hit;
   assign st_ready      = !full;
   assign exc_ades      = exc_ades_q;
   assign m_data_addr   = empty ? 32'h0 : addr_q[rd_idx];
   assign m_data_wdata  = empty ? 32'h0 : wdata_q[rd_idx];
   assign m_data_byteen = empty ? 4'h0  : byteen_q[rd_idx];
   assign m_inst_addr   = empty ? 32'h0 : pc_q[rd_idx];

endmodule
